neuron_mac: RTL and testbench

- Multiply-accumulate neuron stage that sits directly upstream of the sigmoid activation block.
- Accepts a streamed vector of signed Q(16-FRAC).FRAC activation/weight pairs and accumulates their products. On the last beat it adds a bias, rounds, and saturates to 16 bits.
- Emits the result as a single-cycle out_valid pulse with out_data, wired straight to the sigmoid's ena / sigmoid_in.
- Enforces a minimum spacing between result pulses so the sigmoid stage is never re-triggered while still busy.

---
 rtl/neuron_mac.sv | 116 +++++++++++
 tb/tb_neuron_mac.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Multiply-accumulate neuron stage: streams signed fixed-point x*w products into a wide
// accumulator, then adds bias, rounds and saturates to DATA_W bits, pacing result pulses by GAP.
module neuron_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned GAP    = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     sat_flag
);

    localparam int unsigned CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (FRAC-1);

    typedef enum logic [1:0] {
        ST_ACC,
        ST_FIN,
        ST_WAIT
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  bias_q;
    logic        [CNT_W-1:0]   cnt_q;
    logic                      xfer;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_sh;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   res;
    logic signed [DATA_W-1:0]  res_clip;
    logic                      res_sat;

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_ACC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            ST_ACC: begin
                // Held low during reset even though the state register already reads ACC.
                in_ready = ~rst;
                if (in_valid && !rst && in_last) state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == CNT_W'(GAP-1)) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    always_comb begin
        prod     = x_in * w_in;
        prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        bias_sh  = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC;
        sum      = acc_q + bias_sh + RND;
        res      = sum >>> FRAC;
        res_sat  = 1'b0;
        res_clip = res[DATA_W-1:0];
        if (res > RES_MAX) begin
            res_clip = RES_MAX[DATA_W-1:0];
            res_sat  = 1'b1;
        end else if (res < RES_MIN) begin
            res_clip = RES_MIN[DATA_W-1:0];
            res_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            bias_q    <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            unique case (state_q)
                ST_ACC: begin
                    if (xfer) begin
                        acc_q <= acc_q + prod_ext;
                        if (in_last) bias_q <= bias;
                    end
                end
                ST_FIN: begin
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    out_valid <= 1'b1;
                    out_data  <= res_clip;
                    sat_flag  <= res_sat;
                end
                ST_WAIT: cnt_q <= cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: hand-computed vectors for rounding, saturation,
// pacing of back-to-back vectors and reset mid-vector.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic [15:0] bias;
    logic        out_valid;
    logic [15:0] out_data;
    logic        sat_flag;

    int n_assert = 0;
    int n_fail   = 0;

    neuron_mac #(.DATA_W(16), .FRAC(8), .ACC_W(40), .GAP(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .x_in(x_in), .w_in(w_in), .bias(bias),
        .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [15:0] x, input logic [15:0] w,
                             input logic [15:0] b, input logic last);
        x_in = x; w_in = w; bias = b; in_last = last; in_valid = 1'b1;
        wait_ready("beat");
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Called right after the last beat is accepted at edge A: FIN cycle, pulse after A+1,
    // cleared after A+2, ready again after GAP cycles of WAIT (11 more ticks).
    task automatic check_result(input string tag, input logic [15:0] exp_data, input logic exp_sat);
        int n = 0;
        chk({tag, "_fin_no_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(exp_data));
        chk({tag, "_sat"},   32'(sat_flag),  32'(exp_sat));
        tick();
        chk({tag, "_pulse_end"}, 32'(out_valid), 32'd0);
        chk({tag, "_sat_end"},   32'(sat_flag),  32'd0);
        chk({tag, "_data_hold"}, 32'(out_data),  32'(exp_data));
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_wait_len"}, 32'(n), 32'd11);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] exp_v;
        int k, run, last_pulse, pulses, ready_now;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; x_in = '0; w_in = '0; bias = '0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_sat",       32'(sat_flag),  32'd0);
        chk("rst_ready_low", 32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready), 32'd1);

        // 256*512 = 131072 -> 512.0 in Q8 terms = 512
        send_beat(16'd256, 16'd512, 16'd0, 1'b1);
        check_result("single", 16'd512, 1'b0);

        // 65536 - 131072 + 65536 = 0, bias 256 -> 256
        send_beat(16'd256, 16'd256, 16'd0, 1'b0);
        send_beat(16'd512, 16'hFF00, 16'd0, 1'b0);
        send_beat(16'd128, 16'd512, 16'd256, 1'b1);
        check_result("three", 16'd256, 1'b0);

        send_beat(16'd1, 16'd128, 16'd0, 1'b1);
        check_result("rnd_pos_half", 16'd1, 1'b0);
        send_beat(16'hFFFF, 16'd128, 16'd0, 1'b1);
        check_result("rnd_neg_half", 16'd0, 1'b0);
        send_beat(16'hFFFF, 16'd384, 16'd0, 1'b1);
        check_result("rnd_neg_1p5", 16'hFFFF, 1'b0);

        for (int i = 0; i < 3; i++) send_beat(16'd32767, 16'd32767, 16'd0, 1'b0);
        send_beat(16'd32767, 16'd32767, 16'd0, 1'b1);
        check_result("sat_pos", 16'h7FFF, 1'b1);
        for (int i = 0; i < 3; i++) send_beat(16'd32767, 16'h8000, 16'd0, 1'b0);
        send_beat(16'd32767, 16'h8000, 16'd0, 1'b1);
        check_result("sat_neg", 16'h8000, 1'b1);

        // Back-to-back single-beat vectors with in_valid held high; each beat x=k*256, w=256 -> k*256.
        k = 1; run = 0; last_pulse = -1; pulses = 0;
        x_in = 16'(k * 256); w_in = 16'd256; bias = '0; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                pulses++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                chk("b2b_data", 32'(out_data), 32'(exp_v));
                if (last_pulse >= 0) chk("b2b_spacing", 32'(c - last_pulse), 32'd14);
                last_pulse = c;
            end
            ready_now = int'(in_ready);
            if (ready_now == 0) run++;
            else begin
                if (run != 0) chk("b2b_ready_low", 32'(run), 32'd13);
                run = 0;
            end
            if (ready_now != 0) exp_q.push_back(16'(k * 256));
            tick();
            if (ready_now != 0) begin
                k++;
                x_in = 16'(k * 256);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd5);
        chk("b2b_no_pending", 32'(exp_q.size()), 32'd0);
        wait_ready("b2b_drain");

        // Two partial beats then reset: nothing may come out, and the sum must restart from 0.
        send_beat(16'd256, 16'd256, 16'd0, 1'b0);
        send_beat(16'd256, 16'd256, 16'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_ready_low", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) pulses++;
            tick();
        end
        chk("midrst_no_pulse", 32'(pulses), 32'd0);
        send_beat(16'd256, 16'd256, 16'd0, 1'b1);
        check_result("after_rst", 16'd256, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
